// File: rtl/dm_byteen_responder_pkg.sv
// Shared types and helpers for the data-memory byte-enable responder.
package dm_byteen_responder_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam logic [3:0] BYTEEN_READ = 4'b0000;

    function automatic logic [31:0] lane_mask(input logic [3:0] byteen);
        lane_mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    endfunction

endpackage

// File: rtl/dm_byteen_responder_if.sv
// Request/response/write-log bundle between the CPU MEM stage and the responder.
interface dm_byteen_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wr_log_valid;
    logic [31:0] wr_log_addr;
    logic [31:0] wr_log_data;

    modport master (
        output req_valid, req_addr, req_byteen, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wr_log_valid, wr_log_addr, wr_log_data
    );

    modport slave (
        input  req_valid, req_addr, req_byteen, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output wr_log_valid, wr_log_addr, wr_log_data
    );
endinterface

// File: rtl/dm_lane_merge.sv
// Combinational byte-lane merge of lane-positioned write data into an old word.
module dm_lane_merge
    import dm_byteen_responder_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  byteen_i,
    output logic [31:0] merged_o
);
    logic [31:0] mask;

    assign mask     = lane_mask(byteen_i);
    assign merged_o = (old_i & ~mask) | (wdata_i & mask);
endmodule

// File: rtl/dm_byteen_responder.sv
// Memory-side responder: zero-fill sweep after reset, then wait-stated byte-enable
// reads/writes against a word array with a write log.
//   state     | meaning
//   ST_CLEAR  | zero one array word per cycle, not ready
//   ST_IDLE   | ready; capture request on handshake
//   ST_WAIT   | burning wait states, counter down to 0
//   ST_COMMIT | access array at this edge, register response
module dm_byteen_responder
    import dm_byteen_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    dm_byteen_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [31:2]           addr_q, addr_d;
    logic [3:0]            byteen_q, byteen_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  wr_log_valid_q, wr_log_valid_d;
    logic [31:0]           wr_log_addr_q, wr_log_addr_d;
    logic [31:0]           wr_log_data_q, wr_log_data_d;

    logic [31:0]           mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wdata;

    logic                  handshake;
    logic                  in_range;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           old_word;
    logic [31:0]           merged;

    assign handshake = bus.req_valid & bus.req_ready;
    assign in_range  = (addr_q[31:ADDR_WIDTH+2] == '0);
    assign is_write  = (byteen_q != BYTEEN_READ);
    assign word_idx  = addr_q[ADDR_WIDTH+1:2];
    assign old_word  = mem_q[word_idx];

    dm_lane_merge u_merge (
        .old_i    (old_word),
        .wdata_i  (wdata_q),
        .byteen_i (byteen_q),
        .merged_o (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            clr_idx_q <= '0;
            addr_q    <= '0;
            byteen_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            addr_q    <= addr_d;
            byteen_q  <= byteen_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        addr_d    = addr_q;
        byteen_d  = byteen_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (handshake) begin
                    addr_d   = bus.req_addr[31:2];
                    byteen_d = bus.req_byteen;
                    wdata_d  = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_COMMIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
    end

    // Response fields hold their last value; only the valid/err flags pulse.
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        mem_we         = 1'b0;
        mem_idx        = clr_idx_q;
        mem_wdata      = '0;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        wr_log_valid_d = 1'b0;
        wr_log_addr_d  = wr_log_addr_q;
        wr_log_data_d  = wr_log_data_q;
        case (state_q)
            ST_CLEAR: mem_we = 1'b1;
            ST_COMMIT: begin
                rsp_valid_d = 1'b1;
                if (!in_range) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (is_write) begin
                    mem_we         = 1'b1;
                    mem_idx        = word_idx;
                    mem_wdata      = merged;
                    rsp_rdata_d    = merged;
                    wr_log_valid_d = 1'b1;
                    wr_log_addr_d  = {addr_q, 2'b00};
                    wr_log_data_d  = merged;
                end else begin
                    rsp_rdata_d = old_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            wr_log_valid_q <= 1'b0;
            wr_log_addr_q  <= '0;
            wr_log_data_q  <= '0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            wr_log_valid_q <= wr_log_valid_d;
            wr_log_addr_q  <= wr_log_addr_d;
            wr_log_data_q  <= wr_log_data_d;
        end
    end

    // No reset on the array: contents come only from the CLEAR sweep and commits.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.wr_log_valid = wr_log_valid_q;
    assign bus.wr_log_addr  = wr_log_addr_q;
    assign bus.wr_log_data  = wr_log_data_q;
endmodule

// File: tb/tb_dm_byteen_responder.sv
// Directed bench for dm_byteen_responder with ADDR_WIDTH=4, WAIT_CYCLES=1.
module tb_dm_byteen_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_byteen_responder_if bus ();

    dm_byteen_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         output int waited);
        bus.req_addr   = a;
        bus.req_byteen = be;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic err,
                            output logic logv, output logic [31:0] la, output logic [31:0] ld,
                            output logic rdy, output logic any_log);
        lat = 0;
        any_log = 1'b0;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            if (bus.wr_log_valid === 1'b1) any_log = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        rd   = bus.rsp_rdata;
        err  = bus.rsp_err;
        logv = bus.wr_log_valid;
        la   = bus.wr_log_addr;
        ld   = bus.wr_log_data;
        rdy  = bus.req_ready;
        if (logv === 1'b1) any_log = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    int          w, lat, n;
    logic [31:0] rd, la, ld;
    logic        err, logv, rdy, anyl, seen;
    logic [31:0] model [16];

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_byteen = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_ready",   32'(bus.req_ready),    32'd0);
        chk("rst_rsp_v",   32'(bus.rsp_valid),    32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err),      32'd0);
        chk("rst_log_v",   32'(bus.wr_log_valid), 32'd0);
        chk("rst_rdata",   bus.rsp_rdata,         32'd0);
        chk("rst_log_a",   bus.wr_log_addr,       32'd0);
        chk("rst_log_d",   bus.wr_log_data,       32'd0);

        // 1: sweep length, then read top word
        reset = 1'b1;
        wait_ready(n);
        chk("t1_clear_cycles", 32'(n), 32'd16);
        issue(32'h3C, 4'b0000, 32'h0, w);
        chk("t1_acc_wait", 32'(w), 32'd0);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t1_lat",   32'(lat),  32'd2);
        chk("t1_rdata", rd,        32'h0);
        chk("t1_err",   32'(err),  32'd0);
        chk("t1_logv",  32'(anyl), 32'd0);

        // 2: full-word write
        issue(32'h08, 4'b1111, 32'hDEADBEEF, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t2_lat",   32'(lat),  32'd2);
        chk("t2_logv",  32'(logv), 32'd1);
        chk("t2_loga",  la,        32'h08);
        chk("t2_logd",  ld,        32'hDEADBEEF);
        chk("t2_rdata", rd,        32'hDEADBEEF);
        chk("t2_err",   32'(err),  32'd0);
        issue(32'h08, 4'b0000, 32'h0, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t2_read",  rd,        32'hDEADBEEF);
        chk("t2_rlog",  32'(anyl), 32'd0);

        // 3: single-lane write at unaligned byte address
        issue(32'h0A, 4'b0100, 32'h00AA0000, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t3_logv", 32'(logv), 32'd1);
        chk("t3_loga", la,        32'h08);
        chk("t3_logd", ld,        32'hDEAABEEF);
        issue(32'h08, 4'b0000, 32'h0, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t3_read", rd,        32'hDEAABEEF);

        // 4: non-contiguous lanes, then back-to-back read in the rsp cycle
        issue(32'h0A, 4'b1001, 32'h11000022, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t4_logd",     ld,       32'h11AABE22);
        chk("t4_rdata",    rd,       32'h11AABE22);
        chk("t4_ready_rsp", 32'(rdy), 32'd1);
        issue(32'h08, 4'b0000, 32'h0, w);
        chk("t4_b2b_wait", 32'(w),   32'd0);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t4_b2b_lat",  32'(lat), 32'd2);
        chk("t4_b2b_read", rd,       32'h11AABE22);

        // 5: out-of-range write and read
        issue(32'h40, 4'b1111, 32'hCAFEF00D, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t5_err",   32'(err),  32'd1);
        chk("t5_rdata", rd,        32'h0);
        chk("t5_log",   32'(anyl), 32'd0);
        issue(32'hFFFF_FFFC, 4'b0000, 32'h0, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t5_rd_err", 32'(err), 32'd1);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        model[2] = 32'h11AABE22;
        for (int i = 0; i < 16; i++) begin
            issue(32'(i * 4), 4'b0000, 32'h0, w);
            wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
            chk($sformatf("t5_word%0d", i), rd, model[i]);
        end

        // 6: reset during WAIT aborts the write
        issue(32'h04, 4'b1111, 32'h12345678, w);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || bus.wr_log_valid !== 1'b0) seen = 1'b1;
        end
        chk("t6_no_rsp", 32'(seen), 32'd0);
        reset = 1'b1;
        wait_ready(n);
        chk("t6_clear_cycles", 32'(n), 32'd16);
        issue(32'h04, 4'b0000, 32'h0, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t6_read04", rd, 32'h0);
        issue(32'h08, 4'b0000, 32'h0, w);
        wait_rsp(lat, rd, err, logv, la, ld, rdy, anyl);
        chk("t6_read08", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
